// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Each granted request runs IDLE -> ACCESS -> RESPOND, one request per three cycles.
module mem_arbiter #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             reqValid_0,
  input  logic             reqWrite_0,
  input  logic [DEPTH-1:0] reqAddress_0,
  input  logic [WIDTH-1:0] reqWriteData_0,
  output logic             reqReady_0,
  output logic             respValid_0,
  output logic [WIDTH-1:0] respReadData_0,
  input  logic             reqValid_1,
  input  logic             reqWrite_1,
  input  logic [DEPTH-1:0] reqAddress_1,
  input  logic [WIDTH-1:0] reqWriteData_1,
  output logic             reqReady_1,
  output logic             respValid_1,
  output logic [WIDTH-1:0] respReadData_1,
  output logic             memWriteEnable,
  output logic [DEPTH-1:0] memAddress,
  output logic [WIDTH-1:0] memWriteData,
  input  logic [WIDTH-1:0] memReadData,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_lastGrant;
  logic             r_grant;
  logic             r_write;
  logic [DEPTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             w_any;
  logic             w_sel;
  logic             w_accept;

  // With both requesting, the one not served last time wins.
  always_comb begin
    w_any    = reqValid_0 | reqValid_1;
    w_sel    = (reqValid_0 && reqValid_1) ? ~r_lastGrant : reqValid_1;
    w_accept = (r_state == S_IDLE) && w_any && rstN;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= S_IDLE;
      r_lastGrant <= 1'b1;
      r_grant     <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_lastGrant <= w_sel;
        r_grant     <= w_sel;
        r_write     <= w_sel ? reqWrite_1     : reqWrite_0;
        r_addr      <= w_sel ? reqAddress_1   : reqAddress_0;
        r_wdata     <= w_sel ? reqWriteData_1 : reqWriteData_0;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    reqReady_0     = 1'b0;
    reqReady_1     = 1'b0;
    respValid_0    = 1'b0;
    respValid_1    = 1'b0;
    respReadData_0 = '0;
    respReadData_1 = '0;
    memWriteEnable = 1'b0;
    memAddress     = '0;
    memWriteData   = '0;
    busy           = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          reqReady_0 = ~w_sel;
          reqReady_1 = w_sel;
          w_next     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        memWriteEnable = r_write;
        memAddress     = r_addr;
        memWriteData   = r_wdata;
        w_next         = S_RESPOND;
      end
      S_RESPOND: begin
        if (r_grant) begin
          respValid_1    = 1'b1;
          respReadData_1 = r_write ? '0 : memReadData;
        end else begin
          respValid_0    = 1'b1;
          respReadData_0 = r_write ? '0 : memReadData;
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4: address width in bits; the memory holds 2**DEPTH words.
REQ-002 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstN, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have, for each requester i in {0,1}, these ports:
- reqValid_i, input, 1: request present.
- reqWrite_i, input, 1: 1 = write, 0 = read.
- reqAddress_i, input, DEPTH: target address.
- reqWriteData_i, input, WIDTH: write data.
- reqReady_i, output, 1: request accepted this cycle.
- respValid_i, output, 1: one-cycle completion pulse.
- respReadData_i, output, WIDTH: read result.
REQ-006 SHALL have the following single-port synchronous memory interface:
- memWriteEnable, output, 1: memory write enable.
- memAddress, output, DEPTH: memory address.
- memWriteData, output, WIDTH: memory write data.
- memReadData, input, WIDTH: memory read data; valid one cycle after memAddress is presented.
REQ-007 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-008 SHALL implement a three-state FSM IDLE -> ACCESS -> RESPOND -> IDLE, with no other states or transitions.
REQ-009 In IDLE with no reqValid, the FSM SHALL remain in IDLE, hold all outputs low, and keep lastGrant unchanged.
REQ-010 In IDLE with at least one reqValid, SHALL grant exactly one requester:
- reqReady is asserted combinationally to that requester only.
- That requester's write flag, address and write data are captured on the same edge.
- The FSM moves to ACCESS.
REQ-011 Arbitration SHALL be round-robin:
- If only one requester is valid, that requester wins.
- If both are valid, the requester other than lastGrant wins.
- lastGrant updates to the winner on the accept edge.
REQ-012 In ACCESS, memAddress and memWriteData SHALL come from the captured registers, and memWriteEnable SHALL equal the captured write flag; the FSM moves to RESPOND.
REQ-013 In RESPOND, SHALL do the following for exactly one cycle, then move to IDLE:
- Pulse respValid of the granted requester high.
- Drive respReadData of that requester with memReadData on reads and with 0 on writes.
REQ-014 memWriteEnable SHALL be low in IDLE and RESPOND; memAddress and memWriteData SHALL be 0 outside ACCESS.
REQ-015 respReadData_i SHALL be 0 whenever respValid_i is low.
REQ-016 reqReady_i SHALL be low outside IDLE; requesters hold their request stable until reqReady.
REQ-017 Latency and throughput:
- An accept on edge T SHALL cause the memory access in cycle T+1 and respValid in cycle T+2.
- Peak throughput SHALL be one request per 3 cycles.
REQ-018 A request arriving while busy SHALL wait, with no loss; it is granted in the first IDLE cycle, i.e. the cycle after RESPOND.
REQ-019 A write then a read to the same address SHALL return the newly written data.

Reset
REQ-020 On rstN low, immediately and independent of clk, SHALL apply the following:
- FSM = IDLE.
- lastGrant = 1, so requester 0 wins the first contest.
- Captured registers = 0.
- All outputs = 0.
REQ-021 A reset during ACCESS or RESPOND SHALL abort the transaction:
- No respValid is produced.
- memWriteEnable drops immediately.
- The request is not retried by the block.
REQ-022 After rstN rises, the first request SHALL be accepted no earlier than the first rising clk edge with rstN high.

Verification
REQ-023 Single write then read:
- Stimulus: requester 0 writes 0xA5 to address 3, then reads address 3.
- Response: write respValid_0 at T+2 with data 0; read respValid_0 with respReadData_0 = 0xA5; respValid_1 never asserts.
REQ-024 Simultaneous requests after reset:
- Stimulus: both requesters valid and held.
- Response: grants alternate 0,1,0,1; each response arrives 2 cycles after its reqReady; no two grants are closer than 3 cycles.
REQ-025 Request while busy:
- Stimulus: requester 1 raises reqValid during ACCESS of requester 0.
- Response: reqReady_1 is asserted in the cycle after requester 0's respValid, and the data is unchanged.
REQ-026 Reset mid-write:
- Stimulus: rstN low during ACCESS of a write of 0x3C to address 7.
- Response: memWriteEnable = 0, busy = 0 and all resp outputs = 0 immediately; no respValid follows.
REQ-027 Address wrap:
- Stimulus: write 0xFF to address 15 (DEPTH = 4), then read address 15 and address 0.
- Response: reads return 0xFF and the previously written value at 0, respectively; there is no aliasing.
